// File: rtl/msrv2_wr_en_pipe_generator.sv
`default_nettype none
// ============================================================================
// Module   : msrv2_wr_en_pipe_generator
// Brief    : LAT-deep per-channel write-enable pipeline with flush kill,
//            post-flush shadow window and saturating drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module msrv2_wr_en_pipe_generator #(
    parameter int                NUM_CH     = 2,
    parameter int                LAT        = 1,
    parameter int                SHADOW     = 2,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}},
    parameter int                CNT_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              stall_in,
    input  logic [NUM_CH-1:0] wr_en_reg_in,
    output logic [NUM_CH-1:0] wr_en_file_out,
    output logic              busy_out,
    output logic [1:0]        state_out,
    output logic [CNT_W-1:0]  drop_cnt_out
);
    localparam logic [1:0] C_ST_RUN      = 2'b00;
    localparam logic [1:0] C_ST_FLUSH    = 2'b01;
    localparam logic [1:0] C_ST_SHADOW   = 2'b10;
    localparam logic [3:0] C_SHADOW_LAST = (SHADOW > 0) ? 4'(SHADOW - 1) : 4'd0;

    logic [LAT-1:0][NUM_CH-1:0] r_stg;
    logic [1:0]                 r_state;
    logic [3:0]                 r_shadow_cnt;
    logic [CNT_W-1:0]           r_drop_cnt;

    logic [NUM_CH-1:0]          w_kill_mask;
    logic [NUM_CH-1:0]          w_flush_mask;
    logic [NUM_CH-1:0]          w_stg_any;
    logic [LAT-1:0][NUM_CH-1:0] w_stg_src;
    logic                       w_drop;

    // Flush clears masked bits immediately; the FLUSH/SHADOW states also block new inputs.
    assign w_flush_mask = FLUSH_MASK & {NUM_CH{flush_in}};
    assign w_kill_mask  = (flush_in || (r_state != C_ST_RUN)) ? FLUSH_MASK : '0;

    always_comb begin
        w_stg_any    = '0;
        w_stg_src    = '0;
        w_stg_src[0] = wr_en_reg_in & ~w_kill_mask;
        for (int k = 0; k < LAT; k++) begin
            w_stg_any = w_stg_any | r_stg[k];
        end
        for (int k = 1; k < LAT; k++) begin
            w_stg_src[k] = r_stg[k-1];
        end
    end

    assign w_drop = (!stall_in && (|(wr_en_reg_in & w_kill_mask))) ||
                    (|(w_stg_any & w_flush_mask));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_stg <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (stall_in) begin
                    r_stg[k] <= r_stg[k] & ~w_flush_mask;
                end else begin
                    r_stg[k] <= w_stg_src[k] & ~w_flush_mask;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= C_ST_RUN;
            r_shadow_cnt <= 4'd0;
        end else begin
            case (r_state)
                C_ST_RUN: begin
                    if (flush_in) begin
                        r_state <= C_ST_FLUSH;
                    end
                end
                C_ST_FLUSH: begin
                    if (!flush_in) begin
                        if (SHADOW > 0) begin
                            r_state      <= C_ST_SHADOW;
                            r_shadow_cnt <= C_SHADOW_LAST;
                        end else begin
                            r_state <= C_ST_RUN;
                        end
                    end
                end
                C_ST_SHADOW: begin
                    if (flush_in) begin
                        r_state <= C_ST_FLUSH;
                    end else if (r_shadow_cnt == 4'd0) begin
                        r_state <= C_ST_RUN;
                    end else begin
                        r_shadow_cnt <= r_shadow_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= C_ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    // Stall hides the last stage so a held enable commits only once, on release.
    assign wr_en_file_out = r_stg[LAT-1] & ~{NUM_CH{stall_in}} & ~w_flush_mask;
    assign busy_out       = |w_stg_any;
    assign state_out      = r_state;
    assign drop_cnt_out   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msrv2_wr_en_pipe_generator.sv
`default_nettype none
// Bench for msrv2_wr_en_pipe_generator: two parameter sets, vector table,
// hand-written corner sequences and random traffic against a time-since-flush model.
module tb_msrv2_wr_en_pipe_generator;

    logic       clk = 1'b0;
    logic       rst, flush, stall;
    logic [1:0] din;
    logic [1:0] out_a, out_b, st_a, st_b;
    logic       busy_a, busy_b;
    logic [7:0] drop_a;
    logic [3:0] drop_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    msrv2_wr_en_pipe_generator #(
        .NUM_CH(2), .LAT(2), .SHADOW(2), .FLUSH_MASK(2'b11), .CNT_W(8)
    ) dut_a (
        .clk_in(clk), .rst_in(rst), .flush_in(flush), .stall_in(stall),
        .wr_en_reg_in(din), .wr_en_file_out(out_a), .busy_out(busy_a),
        .state_out(st_a), .drop_cnt_out(drop_a)
    );

    msrv2_wr_en_pipe_generator #(
        .NUM_CH(2), .LAT(3), .SHADOW(3), .FLUSH_MASK(2'b01), .CNT_W(4)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .flush_in(flush), .stall_in(stall),
        .wr_en_reg_in(din), .wr_en_file_out(out_b), .busy_out(busy_b),
        .state_out(st_b), .drop_cnt_out(drop_b)
    );

    // Model: stage contents plus the number of cycles since flush_in was last high.
    logic [1:0] m_pipe [2][3];
    int         m_age  [2];
    int         m_drop [2];

    function automatic int p_lat(int i);     return (i == 0) ? 2 : 3;    endfunction
    function automatic int p_shadow(int i);  return (i == 0) ? 2 : 3;    endfunction
    function automatic int p_cmax(int i);    return (i == 0) ? 255 : 15; endfunction
    function automatic logic [1:0] p_mask(int i); return (i == 0) ? 2'b11 : 2'b01; endfunction

    task automatic chk(string name, int inst, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, got, want);
        end
    endtask

    task automatic check_model();
        logic [1:0] any, eo;
        int         es;
        for (int i = 0; i < 2; i++) begin
            any = 2'b00;
            for (int k = 0; k < p_lat(i); k++) any = any | m_pipe[i][k];
            eo = stall ? 2'b00 : (m_pipe[i][p_lat(i)-1] & ~(flush ? p_mask(i) : 2'b00));
            if (m_age[i] == 1)                                  es = 1;
            else if (m_age[i] >= 2 && m_age[i] <= p_shadow(i) + 1) es = 2;
            else                                                es = 0;
            chk("m_out",   i, (i == 0) ? out_a  : out_b,  eo);
            chk("m_busy",  i, (i == 0) ? busy_a : busy_b, (any != 2'b00) ? 1 : 0);
            chk("m_state", i, (i == 0) ? st_a   : st_b,   es);
            chk("m_drop",  i, (i == 0) ? drop_a : drop_b, m_drop[i]);
        end
    endtask

    task automatic model_update();
        logic [1:0] any, kill, fm;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                for (int k = 0; k < 3; k++) m_pipe[i][k] = 2'b00;
                m_age[i]  = 1000;
                m_drop[i] = 0;
            end else begin
                any = 2'b00;
                for (int k = 0; k < p_lat(i); k++) any = any | m_pipe[i][k];
                kill = (flush || m_age[i] <= p_shadow(i) + 1) ? p_mask(i) : 2'b00;
                fm   = flush ? p_mask(i) : 2'b00;
                if (((!stall && (din & kill) != 2'b00) || ((any & fm) != 2'b00)) &&
                    m_drop[i] < p_cmax(i))
                    m_drop[i]++;
                if (stall) begin
                    for (int k = 0; k < p_lat(i); k++) m_pipe[i][k] = m_pipe[i][k] & ~fm;
                end else begin
                    for (int k = p_lat(i) - 1; k >= 1; k--) m_pipe[i][k] = m_pipe[i][k-1] & ~fm;
                    m_pipe[i][0] = din & ~kill;
                end
                if (flush)              m_age[i] = 1;
                else if (m_age[i] < 1000) m_age[i] = m_age[i] + 1;
            end
        end
    endtask

    task automatic apply(logic r, logic f, logic s, logic [1:0] d);
        rst = r; flush = f; stall = s; din = d;
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    typedef struct {
        logic       flush;
        logic       stall;
        logic [1:0] din;
        logic [1:0] eo;
        logic       eb;
        logic [1:0] es;
        int         ed;
    } vec_t;

    vec_t tbl[28];

    initial begin
        // Expected values for dut_a (LAT=2, SHADOW=2, mask 11), starting from reset.
        tbl[0]  = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 0};
        tbl[1]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 0};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 0};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 0};
        tbl[4]  = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 0};
        tbl[5]  = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 0};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 0};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1};
        tbl[10] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1};
        tbl[13] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 1};
        tbl[14] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 2};
        tbl[15] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 3};
        tbl[16] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 3};
        tbl[17] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 2'b00, 3};
        tbl[18] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 3};
        tbl[19] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 3};
        tbl[20] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3};
        tbl[21] = '{1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 3};
        tbl[22] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3};
        tbl[23] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 3};
        tbl[24] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 3};
        tbl[25] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 3};
        tbl[26] = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 3};
        tbl[27] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3};

        rst = 1'b0; flush = 1'b0; stall = 1'b0; din = 2'b00;
        repeat (2) advance();

        for (int v = 0; v < 28; v++) begin
            apply(1'b1, tbl[v].flush, tbl[v].stall, tbl[v].din);
            chk("tbl_out",   v, out_a,  tbl[v].eo);
            chk("tbl_busy",  v, busy_a, tbl[v].eb);
            chk("tbl_state", v, st_a,   tbl[v].es);
            chk("tbl_drop",  v, drop_a, tbl[v].ed);
            advance();
        end

        // Immune channel survives a flush (dut_b, mask 01, LAT=3).
        apply(1'b0, 1'b0, 1'b0, 2'b00); advance();
        repeat (3) begin apply(1'b1, 1'b0, 1'b0, 2'b11); advance(); end
        apply(1'b1, 1'b1, 1'b0, 2'b00);
        chk("t5_out_flush", 1, out_b, 2'b10);
        advance();
        apply(1'b1, 1'b0, 1'b0, 2'b00);
        chk("t5_state", 1, st_b, 2'b01);
        chk("t5_out1", 1, out_b, 2'b10);
        chk("t5_drop", 1, drop_b, 1);
        advance();
        apply(1'b1, 1'b0, 1'b0, 2'b00);
        chk("t5_out2", 1, out_b, 2'b10);
        advance();
        apply(1'b1, 1'b0, 1'b0, 2'b00);
        chk("t5_out3", 1, out_b, 2'b00);
        advance();

        // Reset in the middle of a shadow window while dut_b is busy.
        apply(1'b1, 1'b1, 1'b0, 2'b00); advance();
        apply(1'b1, 1'b0, 1'b0, 2'b10); advance();
        apply(1'b1, 1'b0, 1'b0, 2'b10);
        chk("t6_pre_state", 1, st_b, 2'b10);
        chk("t6_pre_busy", 1, busy_b, 1);
        advance();
        apply(1'b0, 1'b0, 1'b0, 2'b10); advance();
        apply(1'b1, 1'b0, 1'b0, 2'b00);
        chk("t6_out", 0, out_a, 0);   chk("t6_out", 1, out_b, 0);
        chk("t6_busy", 0, busy_a, 0); chk("t6_busy", 1, busy_b, 0);
        chk("t6_state", 0, st_a, 0);  chk("t6_state", 1, st_b, 0);
        chk("t6_drop", 0, drop_a, 0); chk("t6_drop", 1, drop_b, 0);
        advance();

        // Counter saturation: one drop per cycle for 2^8+3 cycles.
        repeat (259) begin apply(1'b1, 1'b1, 1'b0, 2'b11); advance(); end
        apply(1'b1, 1'b0, 1'b0, 2'b00);
        chk("sat_drop", 0, drop_a, 8'hFF);
        chk("sat_drop", 1, drop_b, 4'hF);
        advance();
        repeat (6) begin apply(1'b1, 1'b0, 1'b0, 2'b00); advance(); end

        // Random traffic, including flush+stall overlap and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
